// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-fetch bus between fetch_ctrl, instr_mem, hazard/branch logic and decode
//   imem_addr/imem_instr          : combinational instr_mem read port
//   stall/redirect_valid/redirect_pc : pipeline control into fetch
//   if_pc/if_instr/if_valid       : IF/ID output stage
//   fault/fault_pc                : sticky fetch-range fault report
// master is the fetch_ctrl side, slave is the environment side.
interface fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        fault;
  logic [31:0] fault_pc;
  modport master (
    output imem_addr, if_pc, if_instr, if_valid, fault, fault_pc,
    input  imem_instr, stall, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_addr, if_pc, if_instr, if_valid, fault, fault_pc,
    output imem_instr, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC and the IF/ID output stage
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_ctrl_if.master (instr_mem port, stall/redirect in, IF/ID and fault out)
// Define FETCH_BOUNDS_CHECK_EN to enable the sticky fetch-range fault (FAULT state);
// otherwise fault and fault_pc are tied to zero and any pc is fetched.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
`ifdef FETCH_BOUNDS_CHECK_EN
  parameter int unsigned INSTR_MEM_SIZE_BYTES = 1024,
`endif
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);
`ifdef FETCH_BOUNDS_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
`else
  typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] target;
  assign target = bus.redirect_pc & ~32'h3;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
`endif
    if (state_q == BOOT) begin
      state_d = RUN;
      pc_d    = bus.redirect_valid ? target : pc_q;
    end else if (state_q == RUN) begin
      if (bus.redirect_valid) begin
        pc_d       = target;
        if_pc_d    = '0;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end else if (!bus.stall) begin
`ifdef FETCH_BOUNDS_CHECK_EN
        if (pc_q >= 32'(INSTR_MEM_SIZE_BYTES)) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
        end else
`endif
        begin
          if_pc_d    = pc_q;
          if_instr_d = bus.imem_instr;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
`endif
    end
  end
  assign bus.imem_addr = pc_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_valid  = if_valid_q;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign bus.fault     = fault_q;
  assign bus.fault_pc  = fault_pc_q;
`else
  assign bus.fault     = 1'b0;
  assign bus.fault_pc  = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a spec-level fetch model
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk, rst;
  fetch_ctrl_if bus ();
  fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [256];
  logic [31:0] prog [4];
  int passed = 0;
  int total = 0;
  logic [31:0] m_pc, m_if_pc, m_if_instr, m_fault_pc;
  logic        m_valid, m_fault, m_boot;
  logic [161:0] dut_v, mdl_v;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd1024) ? mem[a[9:2]] : ~a;
  endfunction
  assign bus.imem_instr = mem_word(bus.imem_addr);
  assign dut_v = {bus.imem_addr, bus.if_pc, bus.if_instr, bus.if_valid, bus.fault, bus.fault_pc};
  assign mdl_v = {m_pc, m_if_pc, m_if_instr, m_valid, m_fault, m_fault_pc};
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic rs);
    bus.stall = s;
    bus.redirect_valid = r;
    bus.redirect_pc = rp;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      m_pc = 32'h0; m_if_pc = 0; m_if_instr = NOP; m_valid = 0;
      m_fault = 0; m_fault_pc = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0;
      if (r) m_pc = {rp[31:2], 2'b00};
    end else if (m_fault) begin
    end else if (r) begin
      m_pc = {rp[31:2], 2'b00}; m_if_pc = 0; m_if_instr = NOP; m_valid = 0;
    end else if (s) begin
`ifdef FETCH_BOUNDS_CHECK_EN
    end else if (m_pc >= 32'd1024) begin
      m_fault = 1; m_fault_pc = m_pc; m_valid = 0; m_if_instr = NOP;
`endif
    end else begin
      m_if_pc = m_pc; m_if_instr = mem_word(m_pc); m_valid = 1; m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    drive(1, 1, 32'h40, 1);
    drive(0, 0, 0, 1);
    total++;
    if (bus.if_instr !== NOP || bus.if_valid !== 1'b0 || bus.if_pc !== 0 || bus.imem_addr !== 0 ||
        bus.fault !== 1'b0 || bus.fault_pc !== 0)
      $display("FAIL reset: got %h required addr=0 pc=0 instr=%h v=0 fault=0", dut_v, NOP);
    else passed++;
  endtask
  task automatic test_boot_fetch();
    drive(0, 0, 0, 0);
    total++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 0) $display("FAIL boot: got v=%b addr=%h required v=0 addr=0", bus.if_valid, bus.imem_addr);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      total++;
      if (bus.if_pc !== 32'(4 * i) || bus.if_instr !== prog[i] || bus.if_valid !== 1'b1)
        $display("FAIL fetch%0d: got pc=%h instr=%h v=%b required pc=%h instr=%h v=1", i, bus.if_pc, bus.if_instr, bus.if_valid, 4 * i, prog[i]);
      else passed++;
    end
  endtask
  task automatic test_stall();
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      total++;
      if (bus.if_pc !== 32'h4 || bus.if_instr !== 32'h0010_0113 || bus.imem_addr !== 32'h8 || bus.if_valid !== 1'b1)
        $display("FAIL stall%0d: got pc=%h instr=%h addr=%h required pc=4 instr=00100113 addr=8", i, bus.if_pc, bus.if_instr, bus.imem_addr);
      else passed++;
    end
    drive(0, 0, 0, 0);
    total++;
    if (bus.if_pc !== 32'h8 || bus.if_instr !== 32'h0020_81B3) $display("FAIL stall_release: got pc=%h instr=%h required pc=8 instr=002081b3", bus.if_pc, bus.if_instr);
    else passed++;
  endtask
  task automatic test_redirect();
    drive(1, 1, 32'h0000_000E, 0);
    total++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'hC || bus.if_instr !== NOP) $display("FAIL redir_bubble: got v=%b addr=%h instr=%h required v=0 addr=c instr=%h", bus.if_valid, bus.imem_addr, bus.if_instr, NOP);
    else passed++;
    drive(0, 0, 0, 0);
    total++;
    if (bus.if_pc !== 32'hC || bus.if_instr !== 32'h0000_006F || bus.if_valid !== 1'b1) $display("FAIL redir_target: got pc=%h instr=%h required pc=c instr=0000006f", bus.if_pc, bus.if_instr);
    else passed++;
    drive(0, 1, 32'h5, 0);
    drive(1, 0, 0, 0);
    total++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h4) $display("FAIL redir_stall: got v=%b addr=%h required v=0 addr=4", bus.if_valid, bus.imem_addr);
    else passed++;
    drive(0, 0, 0, 0);
    total++;
    if (bus.if_pc !== 32'h4 || bus.if_instr !== 32'h0010_0113 || bus.if_valid !== 1'b1) $display("FAIL redir_stall_release: got pc=%h instr=%h required pc=4 instr=00100113", bus.if_pc, bus.if_instr);
    else passed++;
  endtask
`ifdef FETCH_BOUNDS_CHECK_EN
  task automatic test_fault();
    drive(0, 1, 32'h400, 0);
    drive(0, 0, 0, 0);
    total++;
    if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h400 || bus.if_valid !== 1'b0 || bus.if_instr !== NOP) $display("FAIL fault_set: got f=%b fpc=%h v=%b required f=1 fpc=400 v=0", bus.fault, bus.fault_pc, bus.if_valid);
    else passed++;
    drive(0, 1, 32'h8, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    total++;
    if (bus.fault !== 1'b1 || bus.imem_addr !== 32'h400 || bus.if_valid !== 1'b0) $display("FAIL fault_sticky: got f=%b addr=%h v=%b required f=1 addr=400 v=0", bus.fault, bus.imem_addr, bus.if_valid);
    else passed++;
    drive(0, 0, 0, 1);
    total++;
    if (bus.fault !== 1'b0 || bus.fault_pc !== 0 || bus.imem_addr !== 0) $display("FAIL fault_clear: got f=%b fpc=%h addr=%h required 0/0/0", bus.fault, bus.fault_pc, bus.imem_addr);
    else passed++;
  endtask
`else
  task automatic test_wrap();
    drive(0, 1, 32'hFFFF_FFFC, 0);
    drive(0, 0, 0, 0);
    total++;
    if (bus.if_pc !== 32'hFFFF_FFFC || bus.if_instr !== 32'h0000_0003 || bus.imem_addr !== 0 || bus.fault !== 1'b0)
      $display("FAIL wrap: got pc=%h instr=%h addr=%h f=%b required pc=fffffffc instr=00000003 addr=0 f=0", bus.if_pc, bus.if_instr, bus.imem_addr, bus.fault);
    else passed++;
    drive(0, 0, 0, 0);
    total++;
    if (bus.if_pc !== 0 || bus.if_instr !== 32'h0050_0093 || bus.fault !== 1'b0) $display("FAIL wrap_next: got pc=%h instr=%h required pc=0 instr=00500093", bus.if_pc, bus.if_instr);
    else passed++;
  endtask
`endif
  task automatic test_reset_mid();
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 1, 32'h20, 1);
    total++;
    if (bus.imem_addr !== 0 || bus.if_valid !== 1'b0 || bus.if_instr !== NOP) $display("FAIL rst_mid: got addr=%h v=%b required addr=0 v=0", bus.imem_addr, bus.if_valid);
    else passed++;
    drive(0, 0, 0, 0);
    total++;
    if (bus.imem_addr !== 0 || bus.if_valid !== 1'b0) $display("FAIL rst_boot: got addr=%h v=%b required addr=0 v=0", bus.imem_addr, bus.if_valid);
    else passed++;
    drive(0, 0, 0, 0);
    total++;
    if (bus.if_pc !== 0 || bus.if_instr !== 32'h0050_0093 || bus.if_valid !== 1'b1) $display("FAIL rst_resume: got pc=%h instr=%h required pc=0 instr=00500093", bus.if_pc, bus.if_instr);
    else passed++;
  endtask
  task automatic test_random();
    logic [31:0] rp;
    for (int i = 0; i < 400; i++) begin
      rp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 1279));
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3, rp, $urandom_range(0, 49) == 0);
      total++;
      if (dut_v !== mdl_v) $display("FAIL random cyc=%0d: got %h required %h", i, dut_v, mdl_v);
      else passed++;
    end
  endtask
  initial begin
    prog = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0000_006F};
    for (int i = 0; i < 256; i++) mem[i] = (i < 4) ? prog[i] : $urandom;
    rst = 1;
    bus.stall = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    test_reset();
    test_boot_fetch();
    test_stall();
    test_redirect();
`ifdef FETCH_BOUNDS_CHECK_EN
    test_fault();
`else
    test_wrap();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
